// File: rtl/register_file_pkg.sv
// Shared widths and data/address types for the register file.
package register_file_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/register_file_word.sv
// One DATA_W-bit storage word with a load enable; cleared asynchronously by Reset.
module register_file_word
  import register_file_pkg::*;
(
  input  logic  Clock,
  input  logic  Reset,
  input  logic  Load,
  input  data_t WriteData,
  output data_t Value
);

  data_t word_d;
  data_t word_q;

  always_comb begin
    word_d = word_q;
    if (Load) begin
      word_d = WriteData;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign Value = word_q;

endmodule

// File: rtl/register_file.sv
// 64x16 register file: two combinational read ports, one write port sharing AddressA.
// Define REGISTER_FILE_ZERO_REG_EN to hardwire register 0 to zero.
module register_file
  import register_file_pkg::*;
(
  input  logic  Clock,
  input  logic  Reset,
  input  addr_t AddressA,
  output data_t ReadDataA,
  input  data_t WriteData,
  input  logic  WriteEnable,
  input  addr_t AddressB,
  output data_t ReadDataB
);

  data_t regs [NUM_REGS];

  genvar i;
  for (i = 0; i < NUM_REGS; i++) begin : g_word
`ifdef REGISTER_FILE_ZERO_REG_EN
    if (i == 0) begin : g_zero
      // No storage for entry 0; writes to it simply have nowhere to land.
      assign regs[i] = '0;
    end else begin : g_reg
      logic load;
      assign load = WriteEnable && (AddressA == addr_t'(i));
      register_file_word u_word (
        .Clock     (Clock),
        .Reset     (Reset),
        .Load      (load),
        .WriteData (WriteData),
        .Value     (regs[i])
      );
    end
`else
    logic load;
    assign load = WriteEnable && (AddressA == addr_t'(i));
    register_file_word u_word (
      .Clock     (Clock),
      .Reset     (Reset),
      .Load      (load),
      .WriteData (WriteData),
      .Value     (regs[i])
    );
`endif
  end

  // Reads see stored state only, so a same-cycle write is visible after the edge.
  always_comb begin
    ReadDataA = regs[AddressA];
    ReadDataB = regs[AddressB];
  end

endmodule

// File: tb/tb_register_file.sv
// Directed-vector bench with an expectation queue drained by a separate monitor.
module tb_register_file;
  import register_file_pkg::*;

  logic  Clock;
  logic  Reset;
  addr_t AddressA;
  addr_t AddressB;
  data_t WriteData;
  logic  WriteEnable;
  data_t ReadDataA;
  data_t ReadDataB;

  int n_chk  = 0;
  int n_fail = 0;

  string name_q [$];
  bit    port_q [$];
  data_t exp_q  [$];
  event  sample_ev;

`ifdef REGISTER_FILE_ZERO_REG_EN
  localparam data_t ZERO_REG_EXP = 16'h0000;
`else
  localparam data_t ZERO_REG_EXP = 16'hFFFF;
`endif

  register_file dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .AddressA    (AddressA),
    .ReadDataA   (ReadDataA),
    .WriteData   (WriteData),
    .WriteEnable (WriteEnable),
    .AddressB    (AddressB),
    .ReadDataB   (ReadDataB)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic expect_rd(input string name, input bit port_b, input data_t exp);
    name_q.push_back(name);
    port_q.push_back(port_b);
    exp_q.push_back(exp);
  endtask

  task automatic sample();
    #1;
    -> sample_ev;
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    @(negedge Clock);
  endtask

  // Monitor: compares every queued expectation against the live read ports.
  initial begin
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        string nm;
        bit    pb;
        data_t ex;
        data_t act;
        nm  = name_q.pop_front();
        pb  = port_q.pop_front();
        ex  = exp_q.pop_front();
        act = pb ? ReadDataB : ReadDataA;
        n_chk++;
        if (act !== ex) begin
          n_fail++;
          $display("FAIL %s: port %s got %h expected %h", nm, pb ? "B" : "A", act, ex);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset       = 1'b0;
    WriteEnable = 1'b0;
    WriteData   = '0;
    AddressA    = '0;
    AddressB    = '0;

    // Reset clears immediately, before any clock edge.
    #1;
    Reset    = 1'b1;
    AddressA = 6'd0;
    AddressB = 6'd15;
    expect_rd("rst_addr0", 1'b0, 16'h0000);
    expect_rd("rst_addr15", 1'b1, 16'h0000);
    sample();
    AddressA = 6'd22;
    AddressB = 6'd63;
    expect_rd("rst_addr22", 1'b0, 16'h0000);
    expect_rd("rst_addr63", 1'b1, 16'h0000);
    sample();

    // Writes ignored while Reset is held.
    @(negedge Clock);
    WriteEnable = 1'b1;
    AddressA    = 6'd15;
    WriteData   = 16'h1111;
    tick(1);
    expect_rd("write_during_reset", 1'b0, 16'h0000);
    sample();
    Reset       = 1'b0;
    WriteEnable = 1'b0;

    // Basic write/read.
    @(negedge Clock);
    AddressA    = 6'd15;
    AddressB    = 6'd22;
    WriteEnable = 1'b1;
    WriteData   = 16'hF0F0;
    tick(2);
    expect_rd("write_a15", 1'b0, 16'hF0F0);
    expect_rd("untouched_b22", 1'b1, 16'h0000);
    sample();

    WriteData = 16'h0000;
    tick(2);
    expect_rd("overwrite_a15", 1'b0, 16'h0000);
    sample();

    WriteEnable = 1'b0;
    WriteData   = 16'hAAAA;
    tick(2);
    expect_rd("write_disabled", 1'b0, 16'h0000);
    sample();

    // Boundary addresses and dual read.
    WriteEnable = 1'b1;
    AddressA    = 6'd63;
    WriteData   = 16'h1234;
    tick(1);
    AddressA  = 6'd1;
    WriteData = 16'h5678;
    tick(1);
    WriteEnable = 1'b0;
    AddressA    = 6'd63;
    AddressB    = 6'd1;
    expect_rd("dual_a63", 1'b0, 16'h1234);
    expect_rd("dual_b1", 1'b1, 16'h5678);
    sample();
    AddressB = 6'd63;
    expect_rd("comb_b63", 1'b1, 16'h1234);
    expect_rd("same_addr_a63", 1'b0, 16'h1234);
    sample();

    // Read during write returns old data until the edge.
    AddressA    = 6'd1;
    AddressB    = 6'd1;
    WriteEnable = 1'b1;
    WriteData   = 16'h9999;
    expect_rd("rdw_old_a", 1'b0, 16'h5678);
    expect_rd("rdw_old_b", 1'b1, 16'h5678);
    sample();
    tick(1);
    WriteEnable = 1'b0;
    expect_rd("rdw_new_a", 1'b0, 16'h9999);
    expect_rd("rdw_new_b", 1'b1, 16'h9999);
    sample();

    // Register 0.
    AddressA    = 6'd0;
    WriteEnable = 1'b1;
    WriteData   = 16'hFFFF;
    tick(1);
    WriteEnable = 1'b0;
    AddressB    = 6'd0;
    expect_rd("zero_reg_a", 1'b0, ZERO_REG_EXP);
    expect_rd("zero_reg_b", 1'b1, ZERO_REG_EXP);
    sample();

    // Reset asserted in the middle of a write cycle.
    AddressA    = 6'd5;
    WriteEnable = 1'b1;
    WriteData   = 16'hBEEF;
    tick(1);
    WriteEnable = 1'b0;
    expect_rd("pre_reset_a5", 1'b0, 16'hBEEF);
    sample();
    WriteEnable = 1'b1;
    WriteData   = 16'h7777;
    AddressB    = 6'd63;
    #1;
    Reset = 1'b1;
    expect_rd("midwrite_rst_a5", 1'b0, 16'h0000);
    expect_rd("midwrite_rst_b63", 1'b1, 16'h0000);
    sample();
    tick(1);
    Reset       = 1'b0;
    WriteEnable = 1'b0;
    expect_rd("after_rst_a5", 1'b0, 16'h0000);
    sample();

    // First write after reset release.
    WriteEnable = 1'b1;
    WriteData   = 16'h4321;
    tick(1);
    WriteEnable = 1'b0;
    expect_rd("post_rst_write", 1'b0, 16'h4321);
    sample();

    tick(1);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
